pf_slot_alloc: RTL and testbench

Slot allocator/scheduler for the prefetcher's pool of 2^LOG_DEPTH prefetch-tracking entries. Holds the per-slot valid vector, grants the lowest-index free slot to an allocation requester, and releases slots on completion. Maintains a running occupancy count and a throttle flag. The prefetch engine uses the throttle flag to stop issuing new prefetches when the pool nears full.

---
 rtl/pf_slot_alloc.sv | 127 ++++++++++++
 tb/tb_pf_slot_alloc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pf_slot_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pf_slot_alloc                                                |
// | Description : Slot allocator for the prefetcher's tracking-entry pool.     |
// |               Grants the lowest free slot, releases slots on completion,   |
// |               keeps an occupancy count and a throttle flag.                |
// |               Optional consistency checker enabled by PF_SLOT_CHECK_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pf_slot_alloc #(
  parameter int LOG_DEPTH = 3,
  parameter int THRESH    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [LOG_DEPTH-1:0] alloc_idx,
  input  logic                 free_valid,
  input  logic [LOG_DEPTH-1:0] free_idx,
  input  logic                 flush,
  output logic [(1<<LOG_DEPTH)-1:0] slot_vec,
  output logic [LOG_DEPTH:0]   occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 throttle,
  output logic                 err
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] C_DEPTH  = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] C_THRESH = (LOG_DEPTH+1)'(THRESH);

  logic [DEPTH-1:0]     r_slot_vec;
  logic [LOG_DEPTH:0]   r_occupancy;
  logic [DEPTH-1:0]     w_slot_vec_nxt;
  logic [LOG_DEPTH:0]   w_occupancy_nxt;
  logic [LOG_DEPTH-1:0] w_alloc_idx;
  logic                 w_full;
  logic                 w_alloc_fire;
  logic                 w_free_fire;

  // Status decodes come from the occupancy register only.
  assign w_full    = (r_occupancy == C_DEPTH);
  assign full      = w_full;
  assign empty     = (r_occupancy == '0);
  assign throttle  = (r_occupancy >= C_THRESH);
  assign slot_vec  = r_slot_vec;
  assign occupancy = r_occupancy;

  // Lowest-index free slot; scanning downward lets the lowest hit win.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_slot_vec[i]) begin
        w_alloc_idx = LOG_DEPTH'(i);
      end
    end
  end

  assign alloc_ready  = !w_full;
  assign alloc_idx    = w_alloc_idx;
  assign w_alloc_fire = alloc_valid && !w_full;
  // Releasing a slot that is not busy is ignored entirely.
  assign w_free_fire  = free_valid && r_slot_vec[free_idx];

  // Next-state for the valid vector and counter; flush overrides both ops.
  always_comb begin
    w_slot_vec_nxt  = r_slot_vec;
    w_occupancy_nxt = r_occupancy;
    if (flush) begin
      w_slot_vec_nxt  = '0;
      w_occupancy_nxt = '0;
    end else begin
      // Grant target is a currently-free slot, so it never equals the freed one.
      if (w_alloc_fire) w_slot_vec_nxt[w_alloc_idx] = 1'b1;
      if (w_free_fire)  w_slot_vec_nxt[free_idx]    = 1'b0;
      case ({w_alloc_fire, w_free_fire})
        2'b10:   w_occupancy_nxt = r_occupancy + 1'b1;
        2'b01:   w_occupancy_nxt = r_occupancy - 1'b1;
        default: w_occupancy_nxt = r_occupancy;
      endcase
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_vec  <= '0;
      r_occupancy <= '0;
    end else begin
      r_slot_vec  <= w_slot_vec_nxt;
      r_occupancy <= w_occupancy_nxt;
    end
  end

`ifdef PF_SLOT_CHECK_EN
  logic [LOG_DEPTH:0] w_ones;
  logic               w_double_free;
  logic               r_err;

  // Population count of the valid vector, wide enough to hold DEPTH.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ones = w_ones + (LOG_DEPTH+1)'(r_slot_vec[i]);
    end
  end

  assign w_double_free = free_valid && !r_slot_vec[free_idx];

  // Sticky error: survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((w_ones != r_occupancy) || w_double_free) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pf_slot_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pf_slot_alloc                                             |
// | Description : Directed, table-driven bench for pf_slot_alloc (DEPTH=8,     |
// |               THRESH=6), plus an asynchronous reset sequence.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pf_slot_alloc;

  typedef struct {
    logic       av;
    logic       fv;
    logic [2:0] fidx;
    logic       fl;
    logic       rdy;   // expected alloc_ready before the edge
    logic [2:0] idx;   // expected alloc_idx before the edge
    logic [7:0] vec;   // expected slot_vec after the edge
    logic [3:0] occ;   // expected occupancy after the edge
    logic       e;     // expected err after the edge when checking is built in
  } vec_t;

`ifdef PF_SLOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0;
  logic       alloc_ready;
  logic [2:0] alloc_idx;
  logic       free_valid = 1'b0;
  logic [2:0] free_idx = '0;
  logic       flush = 1'b0;
  logic [7:0] slot_vec;
  logic [3:0] occupancy;
  logic       full, empty, throttle, err;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];

  pf_slot_alloc #(.LOG_DEPTH(3), .THRESH(6)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .free_valid(free_valid), .free_idx(free_idx), .flush(flush),
    .slot_vec(slot_vec), .occupancy(occupancy),
    .full(full), .empty(empty), .throttle(throttle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic fv, input logic [2:0] fidx, input logic fl,
                     input logic rdy, input logic [2:0] idx, input logic [7:0] vec,
                     input logic [3:0] occ, input logic e);
    vec_t v;
    v.av = av; v.fv = fv; v.fidx = fidx; v.fl = fl;
    v.rdy = rdy; v.idx = idx; v.vec = vec; v.occ = occ; v.e = e;
    tbl.push_back(v);
  endtask

  // Registered-state checks, with status flags derived from the expected count.
  task automatic chk_state(input string tag, input logic [7:0] vec, input logic [3:0] occ,
                           input logic e);
    chk({tag, "_vec"},  32'(slot_vec),  32'(vec));
    chk({tag, "_occ"},  32'(occupancy), 32'(occ));
    chk({tag, "_full"}, 32'(full),      32'(occ == 4'd8));
    chk({tag, "_empty"},32'(empty),     32'(occ == 4'd0));
    chk({tag, "_thr"},  32'(throttle),  32'(occ >= 4'd6));
    chk({tag, "_err"},  32'(err),       32'(e & CHK));
  endtask

  initial begin
    // Eight back-to-back grants: idx 0..7, throttle after the 6th, full after the 8th.
    add(1,0,0,0, 1,0, 8'h01,1, 0);
    add(1,0,0,0, 1,1, 8'h03,2, 0);
    add(1,0,0,0, 1,2, 8'h07,3, 0);
    add(1,0,0,0, 1,3, 8'h0F,4, 0);
    add(1,0,0,0, 1,4, 8'h1F,5, 0);
    add(1,0,0,0, 1,5, 8'h3F,6, 0);
    add(1,0,0,0, 1,6, 8'h7F,7, 0);
    add(1,0,0,0, 1,7, 8'hFF,8, 0);
    // Full pool: free 3 with alloc requested -> no grant this cycle.
    add(1,1,3,0, 0,0, 8'hF7,7, 0);
    add(1,0,0,0, 1,3, 8'hFF,8, 0);
    // Flush while full and requesting: nothing granted.
    add(1,0,0,0, 0,0, 8'hFF,8, 0);
    tbl[$].fl = 1'b1; tbl[$].vec = 8'h00; tbl[$].occ = 4'd0;
    // Build 0000_0101 then alloc + free 0 in the same cycle.
    add(1,0,0,0, 1,0, 8'h01,1, 0);
    add(1,0,0,0, 1,1, 8'h03,2, 0);
    add(1,0,0,0, 1,2, 8'h07,3, 0);
    add(0,1,1,0, 1,3, 8'h05,2, 0);
    add(1,1,0,0, 1,1, 8'h06,2, 0);
    add(0,1,1,0, 1,0, 8'h04,1, 0);
    add(0,1,2,0, 1,0, 8'h00,0, 0);
    // Double-free of idx 5 while empty.
    add(0,1,5,0, 1,0, 8'h00,0, 1);
    // Fill to 5, double-free a non-busy slot, then flush with alloc requested.
    add(1,0,0,0, 1,0, 8'h01,1, 1);
    add(1,0,0,0, 1,1, 8'h03,2, 1);
    add(1,0,0,0, 1,2, 8'h07,3, 1);
    add(1,0,0,0, 1,3, 8'h0F,4, 1);
    add(1,0,0,0, 1,4, 8'h1F,5, 1);
    add(0,1,6,0, 1,5, 8'h1F,5, 1);
    add(1,0,0,1, 1,5, 8'h00,0, 1);
    // Refill to 4 for the asynchronous reset sequence.
    add(1,0,0,0, 1,0, 8'h01,1, 1);
    add(1,0,0,0, 1,1, 8'h03,2, 1);
    add(1,0,0,0, 1,2, 8'h07,3, 1);
    add(1,0,0,0, 1,3, 8'h0F,4, 1);

    // Reset state while rst is held.
    #12;
    chk_state("rst", 8'h00, 4'd0, 1'b0);
    chk("rst_rdy", 32'(alloc_ready), 32'd1);
    chk("rst_idx", 32'(alloc_idx),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      alloc_valid = tbl[i].av;
      free_valid  = tbl[i].fv;
      free_idx    = tbl[i].fidx;
      flush       = tbl[i].fl;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(alloc_ready), 32'(tbl[i].rdy));
      if (tbl[i].rdy)
        chk($sformatf("v%0d_idx", i), 32'(alloc_idx), 32'(tbl[i].idx));
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), tbl[i].vec, tbl[i].occ, tbl[i].e);
    end

    // Asynchronous reset between edges at occupancy 4.
    alloc_valid = 1'b0; free_valid = 1'b0; flush = 1'b0;
    #2;
    chk("pre_arst_occ", 32'(occupancy), 32'd4);
    rst = 1'b1;
    #1;
    chk_state("arst", 8'h00, 4'd0, 1'b0);
    chk("arst_rdy", 32'(alloc_ready), 32'd1);
    chk("arst_idx", 32'(alloc_idx),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    // First grant after reset restarts at slot 0.
    alloc_valid = 1'b1;
    #1;
    chk("post_rst_idx", 32'(alloc_idx), 32'd0);
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    chk_state("post_rst", 8'h01, 4'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
